// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow error pulses, optional first-word-fall-through read mode
// and support for any depth (pointers wrap explicitly, not by overflow).
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] AF_LEVEL  = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LEVEL  = CW'(AE_THRESH);
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    // Reject illegal configurations at elaboration rather than misbehaving silently.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be >= 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH must lie in 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] dout_r;
    logic             rd_accept;
    logic             wr_accept;

    // Flags are pure decodes of the registered count.
    assign full         = (count == FULL_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    // A read needs data already present; a write into a full FIFO is allowed
    // only when a read frees a slot on the same edge.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    // Storage array: written on accepted writes only.
    // NOTE: the memory has no reset -- its contents are meaningless until
    // written, and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered read data and error pulses.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, e.g. a same-edge read sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_r    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;

            if (wr_accept) begin
                if (wr_ptr == LAST_SLOT) wr_ptr <= '0;
                else                     wr_ptr <= wr_ptr + 1'b1;
            end

            if (rd_accept) begin
                dout_r <= mem[rd_ptr];
                if (rd_ptr == LAST_SLOT) rd_ptr <= '0;
                else                     rd_ptr <= rd_ptr + 1'b1;
            end

            if (wr_accept && !rd_accept) begin
                count <= count + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Output mux: in FWFT mode the head word is shown while data is present;
    // otherwise (and whenever empty) the last popped word is held.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        dout = dout_r;
        if (FWFT != 0 && !empty) begin
            dout = mem[rd_ptr];
        end
    end

endmodule
